// File: rtl/alu_requant.sv
`default_nettype none
// ============================================================================
//  Module   : alu_requant
//  Purpose  : Two-stage requantizer for A*B+C results. Stage 1 rounds
//             (half toward +inf) and drops SH fractional bits; stage 2
//             saturates to DW_OUT bits. Valid/ready on both sides, sticky
//             overflow flag with synchronous clear.
//  Options  : define ALU_REQUANT_SAT_CNT_EN to add the 16-bit sat_cnt output
//             (count of saturated beats, sticks at 0xFFFF, cleared by ovf_clr).
//  Revision : 1.0 - initial release
// ============================================================================
module alu_requant #(
    parameter int DW_IN   = 48,
    parameter int INT_IN  = 1,
    parameter int DW_OUT  = 24,
    parameter int INT_OUT = 0
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [DW_IN-1:0]  din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [DW_OUT-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    input  logic              ovf_clr,
    output logic              ovf_sticky
`ifdef ALU_REQUANT_SAT_CNT_EN
    ,
    output logic [15:0]       sat_cnt
`endif
);

    localparam int c_flt_in  = DW_IN - INT_IN - 1;
    localparam int c_flt_out = DW_OUT - INT_OUT - 1;
    localparam int c_sh      = c_flt_in - c_flt_out;
    // din sign-extended by one bit so adding the rounding constant never wraps
    localparam int c_sum_w   = DW_IN + 1;
    // width of the rounded value once the SH fractional bits are dropped
    localparam int c_rnd_w   = c_sum_w - c_sh;
    localparam logic [c_sum_w-1:0] c_round = c_sum_w'(1) << (c_sh - 1);
    localparam logic [DW_OUT-1:0]  c_pos_max = {1'b0, {(DW_OUT-1){1'b1}}};
    localparam logic [DW_OUT-1:0]  c_neg_min = {1'b1, {(DW_OUT-1){1'b0}}};

    // A format that needs a left shift or gains integer bits cannot be
    // handled by a pure round-and-clamp path, so refuse to elaborate.
    generate
        if (c_sh < 1 || INT_OUT > INT_IN) begin : g_bad_params
            $error("alu_requant: need FLT_IN > FLT_OUT and INT_OUT <= INT_IN");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic                      s1_valid_q, s1_valid_d;
    logic [c_rnd_w-1:0]        s1_data_q,  s1_data_d;
    logic                      s2_valid_q, s2_valid_d;
    logic [DW_OUT-1:0]         s2_data_q,  s2_data_d;
    logic                      ovf_q,      ovf_d;

    // ------------------------------------------------------------------
    // Combinational datapath / handshake
    // ------------------------------------------------------------------
    logic [c_sum_w-1:0]        w_sum;
    logic [c_rnd_w-1:0]        w_rnd;
    logic                      w_unused_frac;
    logic [c_rnd_w-DW_OUT:0]   w_hi;
    logic                      w_pos_ovf;
    logic                      w_neg_ovf;
    logic [DW_OUT-1:0]         w_clamp;
    logic                      w_s2_free;
    logic                      w_s1_adv;
    logic                      w_sat_enter;

    // Round half toward +inf: add half an output LSB, keep the upper bits.
    // Keeping the top bits of the sum is the arithmetic right shift by SH.
    assign w_sum         = {din[DW_IN-1], din} + c_round;
    assign w_rnd         = w_sum[c_sum_w-1:c_sh];
    assign w_unused_frac = ^w_sum[c_sh-1:0];

    // Bits above the output sign must all copy the sign, else the value
    // does not fit and is clamped toward the side its sign indicates.
    assign w_hi      = s1_data_q[c_rnd_w-1:DW_OUT-1];
    assign w_pos_ovf = ~s1_data_q[c_rnd_w-1] & (|w_hi);
    assign w_neg_ovf =  s1_data_q[c_rnd_w-1] & ~(&w_hi);

    // Stage 2 can take a beat when empty or when its beat is leaving now;
    // stage 1 can take a beat when empty or when it hands off to stage 2.
    assign w_s2_free   = ~s2_valid_q | dout_ready;
    assign w_s1_adv    = ~s1_valid_q | w_s2_free;
    assign w_sat_enter = s1_valid_q & w_s2_free & (w_pos_ovf | w_neg_ovf);

    assign din_ready  = w_s1_adv;
    assign dout       = s2_data_q;
    assign dout_valid = s2_valid_q;
    assign ovf_sticky = ovf_q;

    // Saturating clamp of the stage-1 result onto the output width
    always_comb begin
        w_clamp = s1_data_q[DW_OUT-1:0];
        if (w_pos_ovf) begin
            w_clamp = c_pos_max;
        end else if (w_neg_ovf) begin
            w_clamp = c_neg_min;
        end
    end

    // Next-state for both pipeline stages and the sticky overflow flag
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        if (w_s1_adv) begin
            s1_valid_d = din_valid;
            if (din_valid) begin
                s1_data_d = w_rnd;
            end
        end
        if (w_s2_free) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = w_clamp;
            end
        end
        // a saturation landing on the same edge as a clear keeps the flag set
        ovf_d = w_sat_enter | (ovf_q & ~ovf_clr);
    end

    // Pipeline and flag registers; reset discards anything in flight
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef ALU_REQUANT_SAT_CNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;

    // Saturation counter: increments stick at all-ones, an increment on the
    // clearing edge restarts the count at one
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (w_sat_enter) begin
            if (ovf_clr) begin
                sat_cnt_d = 16'd1;
            end else if (sat_cnt_q != 16'hFFFF) begin
                sat_cnt_d = sat_cnt_q + 16'd1;
            end
        end else if (ovf_clr) begin
            sat_cnt_d = 16'd0;
        end
    end

    // Saturation counter register
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            sat_cnt_q <= 16'd0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt = sat_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/alu_requant.md
ALU_REQUANT -- requirements
Module: alu_requant

Interface
REQ-001 SHALL have parameter DW_IN, default 48: width of the incoming A*B+C result word.
REQ-002 SHALL have parameter INT_IN, default 1: integer bits of din (sign excluded); FLT_IN = DW_IN-INT_IN-1.
REQ-003 SHALL have parameter DW_OUT, default 24: width of the requantized result.
REQ-004 SHALL have parameter INT_OUT, default 0: integer bits of dout (sign excluded); FLT_OUT = DW_OUT-INT_OUT-1.
REQ-005 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-006 SHALL have port n_rst, input, 1: asynchronous, active-high reset (1 = reset).
REQ-007 SHALL have port din, input, DW_IN: signed two's-complement A*B+C result.
REQ-008 SHALL have port din_valid, input, 1: din holds a beat.
REQ-009 SHALL have port din_ready, output, 1: block accepts a beat this cycle.
REQ-010 SHALL have port dout, output, DW_OUT: rounded, saturated result.
REQ-011 SHALL have port dout_valid, output, 1: dout holds a beat.
REQ-012 SHALL have port dout_ready, input, 1: consumer accepts dout.
REQ-013 SHALL have port ovf_clr, input, 1: synchronous clear of ovf_sticky (and sat_cnt).
REQ-014 SHALL have port ovf_sticky, output, 1: set when any beat saturated since last clear.

Function
REQ-015 SHALL transfer a beat on any edge where valid and ready are both 1, on each side independently.
REQ-016 SHALL compute SH = FLT_IN-FLT_OUT; elaboration SHALL fail if SH < 1 or INT_OUT > INT_IN.
REQ-017 Stage 1 SHALL register r = (sign-extended din, DW_IN+1 bits) + 2^(SH-1), arithmetically shifted right by SH (round half toward +inf).
REQ-018 Stage 2 SHALL clamp r to [-2^(DW_OUT-1), 2^(DW_OUT-1)-1] and register it onto dout.
REQ-019 Latency SHALL be exactly 2 cycles from din accept to dout_valid with dout_ready held 1.
REQ-020 Throughput SHALL be one beat per cycle while dout_ready=1.
REQ-021 din_ready SHALL equal NOT stage1_valid OR NOT stage2_valid OR dout_ready (pipeline advances when stage 2 drains).
REQ-022 Beats SHALL leave in acceptance order; none dropped or duplicated under any backpressure pattern.
REQ-023 dout and dout_valid SHALL hold stable while dout_valid=1 and dout_ready=0.
REQ-024 ovf_sticky SHALL set on the edge a clamped beat enters stage 2.
REQ-025 ovf_clr and a simultaneous saturation on the same edge SHALL leave ovf_sticky=1 (set wins).

Reset
REQ-026 n_rst=1 SHALL asynchronously force: both stage valids 0, dout_valid 0, dout 0, ovf_sticky 0, sat_cnt 0.
REQ-027 din_ready SHALL read 1 during and immediately after reset.
REQ-028 Reset mid-transfer SHALL discard all in-flight beats; first beat accepted after release emerges 2 cycles later.

Configuration
REQ-029 Macro ALU_REQUANT_SAT_CNT_EN defined SHALL add output sat_cnt (16 bits): counts saturated beats entering stage 2, sticks at 0xFFFF, cleared by ovf_clr (increment wins on same edge, giving 1).
REQ-030 Without ALU_REQUANT_SAT_CNT_EN, port sat_cnt and its logic SHALL not exist; all other behaviour unchanged.

Verification (defaults DW_IN=48, INT_IN=1, DW_OUT=24, INT_OUT=0, SH=23)
REQ-031 din=0x000000800000, dout_ready=1 -> dout=0x000001 with dout_valid exactly 2 cycles after accept, ovf_sticky=0.
REQ-032 din=0x000000400000 -> dout=0x000001; din=0xFFFFFFC00000 -> dout=0x000000 (half-rounding, both signs).
REQ-033 din=0x7FFFFFFFFFFF -> dout=0x7FFFFF, ovf_sticky=1 (sat_cnt=1 with macro); din=0x800000000000 -> dout=0x800000; ovf_clr pulse -> ovf_sticky=0, sat_cnt=0.
REQ-034 dout_ready=0, offer beats 1,2,3 back-to-back -> din_ready=0 after 2 accepted, dout holds beat 1; dout_ready=1 -> 1,2,3 in order, no gaps once flowing.
REQ-035 Assert n_rst for 1 cycle with 2 beats in flight -> dout_valid=0 immediately, no stale beat afterwards; next beat emerges 2 cycles after accept.
REQ-036 Random valid/ready toggling, 10k beats -> output sequence equals reference model of REQ-017/REQ-018, in order.
